// File: rtl/ex_mdu.sv
// Execute stage with logic/shift/LUI datapath, HI/LO registers and an
// iterative multiply/divide unit that stalls the pipeline while it works.
module ex_mdu #(
  parameter int DW  = 32,
  parameter int SHW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_i,
  input  logic [7:0]    aluop_i,
  input  logic [DW-1:0] reg1_i,
  input  logic [DW-1:0] reg2_i,
  input  logic [4:0]    wd_i,
  input  logic          wreg_i,
  output logic [DW-1:0] wdata_o,
  output logic [4:0]    wd_o,
  output logic          wreg_o,
  output logic          stall_req_o,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  localparam logic [7:0] OP_AND  = 8'h24, OP_ANDI = 8'h59, OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26, OP_XORI = 8'h5B, OP_NOR  = 8'h27;
  localparam logic [7:0] OP_SLL  = 8'h7C, OP_SLLV = 8'h04, OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRLV = 8'h06, OP_SRA  = 8'h03, OP_SRAV = 8'h07;
  localparam logic [7:0] OP_LUI  = 8'h5C;
  localparam logic [7:0] OP_MFHI = 8'h10, OP_MTHI = 8'h11, OP_MFLO = 8'h12;
  localparam logic [7:0] OP_MTLO = 8'h13;
  localparam logic [7:0] OP_MULT = 8'h18, OP_MULTU = 8'h19;
  localparam logic [7:0] OP_DIV  = 8'h1A, OP_DIVU  = 8'h1B;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [SHW-1:0]  cnt;
  logic [DW-1:0]   acc_hi, acc_lo, op_b;
  logic            is_div, neg_q, neg_r, div0;

  // Operand decode for the multiply/divide unit.
  logic            md_op, md_div, md_signed, a_neg, b_neg;
  logic [DW-1:0]   a_mag, b_mag;

  always_comb begin
    md_op     = (aluop_i == OP_MULT) || (aluop_i == OP_MULTU) ||
                (aluop_i == OP_DIV)  || (aluop_i == OP_DIVU);
    md_div    = (aluop_i == OP_DIV)  || (aluop_i == OP_DIVU);
    md_signed = (aluop_i == OP_MULT) || (aluop_i == OP_DIV);
    a_neg     = md_signed & reg1_i[DW-1];
    b_neg     = md_signed & reg2_i[DW-1];
    a_mag     = a_neg ? -reg1_i : reg1_i;
    b_mag     = b_neg ? -reg2_i : reg2_i;
  end

  // Single-cycle result path.
  logic [DW-1:0]  alu_res;
  logic [4:0]     alu_wd;
  logic           alu_wreg;
  logic [SHW-1:0] sa;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    alu_res  = '0;
    alu_wd   = wd_i;
    alu_wreg = wreg_i;
    sa       = reg1_i[SHW-1:0];
    case (aluop_i)
      OP_AND, OP_ANDI:   alu_res = reg1_i & reg2_i;
      OP_OR:             alu_res = reg1_i | reg2_i;
      OP_XOR, OP_XORI:   alu_res = reg1_i ^ reg2_i;
      OP_NOR:            alu_res = ~(reg1_i | reg2_i);
      OP_SLL, OP_SLLV:   alu_res = reg2_i << sa;
      OP_SRL, OP_SRLV:   alu_res = reg2_i >> sa;
      OP_SRA, OP_SRAV:   alu_res = $signed(reg2_i) >>> sa;
      OP_LUI:            alu_res = {reg2_i[DW/2-1:0], reg1_i[DW/2-1:0]};
      OP_MFHI:           alu_res = hi_o;
      OP_MFLO:           alu_res = lo_o;
      OP_MTHI, OP_MTLO:  alu_wreg = 1'b0;
      default: begin
        alu_wd   = '0;
        alu_wreg = 1'b0;
      end
    endcase
  end

  // One iteration: shift-add for multiply, restoring step for divide.
  logic [DW-1:0] step_hi, step_lo;
  logic [DW:0]   shifted, diff, sum;

  always_comb begin
    step_hi = acc_hi;
    step_lo = acc_lo;
    shifted = {acc_hi, acc_lo[DW-1]};
    diff    = shifted - {1'b0, op_b};
    sum     = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, op_b}) : {1'b0, acc_hi};
    if (is_div) begin
      if (!diff[DW]) begin
        step_hi = diff[DW-1:0];
        step_lo = {acc_lo[DW-2:0], 1'b1};
      end else begin
        step_hi = shifted[DW-1:0];
        step_lo = {acc_lo[DW-2:0], 1'b0};
      end
    end else begin
      {step_hi, step_lo} = {sum, acc_lo[DW-1:1]};
    end
  end

  // Sign correction applied at commit.
  logic [2*DW-1:0] prod_fix;
  logic [DW-1:0]   hi_new, lo_new;

  always_comb begin
    prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    if (is_div) begin
      lo_new = neg_q ? -acc_lo : acc_lo;
      hi_new = neg_r ? -acc_hi : acc_hi;
    end else begin
      lo_new = prod_fix[DW-1:0];
      hi_new = prod_fix[2*DW-1:DW];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (md_op && !stall_i)
              state_nxt = (md_div && reg2_i == '0) ? DONE : RUN;
      RUN:  if (cnt == SHW'(DW-1)) state_nxt = DONE;
      DONE: if (!stall_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reset forces the request low even while a mult/div opcode is presented.
  assign stall_req_o = rst & ((state == IDLE && md_op) || state == RUN);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      op_b    <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      div0    <= 1'b0;
      hi_o    <= '0;
      lo_o    <= '0;
      wdata_o <= '0;
      wd_o    <= '0;
      wreg_o  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (!stall_i) begin
          if (md_op) begin
            is_div <= md_div;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            div0   <= md_div && (reg2_i == '0);
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= md_div ? a_mag : b_mag;
            op_b   <= md_div ? b_mag : a_mag;
          end else begin
            wdata_o <= alu_res;
            wd_o    <= alu_wd;
            wreg_o  <= alu_wreg;
            if (aluop_i == OP_MTHI) hi_o <= reg1_i;
            if (aluop_i == OP_MTLO) lo_o <= reg1_i;
          end
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 1'b1;
        end
        DONE: if (!stall_i) begin
          if (!div0) begin
            hi_o <= hi_new;
            lo_o <= lo_new;
          end
          wdata_o <= '0;
          wd_o    <= '0;
          wreg_o  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu: reset abort, shifts/logic, multiply, divide,
// divide-by-zero, signed overflow, commit hold under stall, HI/LO moves.
module tb_ex_mdu;
  localparam int DW  = 32;
  localparam int SHW = 5;

  logic          clk = 1'b0;
  logic          rst, stall_i, wreg_i;
  logic [7:0]    aluop_i;
  logic [DW-1:0] reg1_i, reg2_i;
  logic [4:0]    wd_i;
  logic [DW-1:0] wdata_o, hi_o, lo_o;
  logic [4:0]    wd_o;
  logic          wreg_o, stall_req_o;

  int n_assert = 0;
  int n_fail   = 0;

  ex_mdu #(.DW(DW), .SHW(SHW)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .aluop_i(aluop_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_o(wdata_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .stall_req_o(stall_req_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [4:0] wd,
                       input logic wr);
    aluop_i = op;
    reg1_i  = a;
    reg2_i  = b;
    wd_i    = wd;
    wreg_i  = wr;
  endtask

  // Issue cycle counts as 1; returns in DONE, one step after the edge.
  task automatic run_md(input string tag, input int exp_len);
    int n;
    n = 1;
    #1;
    check({tag, "_req_issue"}, stall_req_o, 1);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (stall_req_o) n++;
      else break;
    end
    check({tag, "_stall_len"}, n, exp_len);
  endtask

  task automatic commit();
    drive(8'h00, '0, '0, 5'd0, 1'b0);
    tick();
  endtask

  initial begin
    rst     = 1'b0;
    stall_i = 1'b0;
    drive(8'h00, '0, '0, 5'd0, 1'b0);
    #3;
    check("rst_wdata", wdata_o, 0);
    check("rst_wreg", wreg_o, 0);
    check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);
    check("rst_stall", stall_req_o, 0);
    #10 rst = 1'b1;
    tick();

    // Shifts, logic, LUI, undefined opcode
    drive(8'h03, 32'd4, 32'hF0000000, 5'd3, 1'b1); tick();
    check("sra", wdata_o, 32'hFF000000);
    check("sra_wd", wd_o, 3);
    check("sra_wreg", wreg_o, 1);
    drive(8'h02, 32'd4, 32'hF0000000, 5'd3, 1'b1); tick();
    check("srl", wdata_o, 32'h0F000000);
    drive(8'h07, 32'd0, 32'hF0000000, 5'd3, 1'b1); tick();
    check("srav_zero", wdata_o, 32'hF0000000);
    drive(8'h7C, 32'd8, 32'h000000FF, 5'd3, 1'b1); tick();
    check("sll", wdata_o, 32'h0000FF00);
    drive(8'h5C, 32'h1234ABCD, 32'h0000BEEF, 5'd3, 1'b1); tick();
    check("lui", wdata_o, 32'hBEEFABCD);
    drive(8'h27, 32'h0F0F0F0F, 32'h00FF00FF, 5'd3, 1'b1); tick();
    check("nor", wdata_o, 32'hF000F000);
    drive(8'h26, 32'h0F0F0F0F, 32'h00FF00FF, 5'd3, 1'b1); tick();
    check("xor", wdata_o, 32'h0FF00FF0);
    drive(8'h55, 32'h0F0F0F0F, 32'h00FF00FF, 5'd9, 1'b1); tick();
    check("undef_wdata", wdata_o, 0);
    check("undef_wreg", wreg_o, 0);
    check("undef_wd", wd_o, 0);

    // Reset in the middle of a multiply
    drive(8'h11, 32'h0000ABCD, '0, 5'd0, 1'b0); tick();
    check("mthi_pre", hi_o, 32'h0000ABCD);
    drive(8'h25, 32'd1, 32'd2, 5'd4, 1'b1); tick();
    check("or", wdata_o, 3);
    drive(8'h18, 32'd5, 32'd7, 5'd0, 1'b0);
    #1 check("mult_req", stall_req_o, 1);
    for (int i = 0; i < 10; i++) tick();
    check("mult_running", stall_req_o, 1);
    #2 rst = 1'b0;
    #1;
    check("abort_wdata", wdata_o, 0);
    check("abort_wd", wd_o, 0);
    check("abort_wreg", wreg_o, 0);
    check("abort_hi", hi_o, 0);
    check("abort_lo", lo_o, 0);
    check("abort_stall", stall_req_o, 0);
    drive(8'h10, '0, '0, 5'd6, 1'b1);
    #2 rst = 1'b1;
    tick();
    check("abort_mfhi", wdata_o, 0);
    check("abort_mfhi_wreg", wreg_o, 1);
    check("abort_idle", stall_req_o, 0);

    // Signed multiply
    drive(8'h18, 32'hFFFFFFFE, 32'd3, 5'd0, 1'b0);
    run_md("mult", 33);
    commit();
    check("mult_hi", hi_o, 32'hFFFFFFFF);
    check("mult_lo", lo_o, 32'hFFFFFFFA);
    check("mult_wreg", wreg_o, 0);
    drive(8'h10, '0, '0, 5'd7, 1'b1); tick();
    check("mfhi", wdata_o, 32'hFFFFFFFF);
    check("mfhi_wreg", wreg_o, 1);
    drive(8'h12, '0, '0, 5'd7, 1'b1); tick();
    check("mflo", wdata_o, 32'hFFFFFFFA);

    // Divides
    drive(8'h1B, 32'd100, 32'd7, 5'd0, 1'b0);
    run_md("divu", 33);
    commit();
    check("divu_lo", lo_o, 14);
    check("divu_hi", hi_o, 2);
    drive(8'h1A, 32'hFFFFFFF9, 32'd2, 5'd0, 1'b0);
    run_md("div_neg", 33);
    commit();
    check("div_neg_lo", lo_o, 32'hFFFFFFFD);
    check("div_neg_hi", hi_o, 32'hFFFFFFFF);

    // Divide by zero, then signed overflow
    drive(8'h1A, 32'd5, 32'd0, 5'd0, 1'b0);
    run_md("div0", 1);
    commit();
    check("div0_lo", lo_o, 32'hFFFFFFFD);
    check("div0_hi", hi_o, 32'hFFFFFFFF);
    drive(8'h1A, 32'h80000000, 32'hFFFFFFFF, 5'd0, 1'b0);
    run_md("div_ovf", 33);
    commit();
    check("div_ovf_lo", lo_o, 32'h80000000);
    check("div_ovf_hi", hi_o, 0);

    // Commit held off by downstream stall while in DONE
    drive(8'h25, 32'h00001200, 32'h00000034, 5'd8, 1'b1); tick();
    check("or_pre", wdata_o, 32'h00001234);
    drive(8'h19, 32'd5, 32'd6, 5'd0, 1'b0);
    run_md("multu", 33);
    drive(8'h00, '0, '0, 5'd0, 1'b0);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_lo", lo_o, 32'h80000000);
      check("hold_wdata", wdata_o, 32'h00001234);
      check("hold_wreg", wreg_o, 1);
    end
    stall_i = 1'b0;
    tick();
    check("multu_lo", lo_o, 30);
    check("multu_hi", hi_o, 0);
    check("multu_wdata", wdata_o, 0);
    check("multu_wreg", wreg_o, 0);

    drive(8'h11, 32'h00001234, '0, 5'd2, 1'b1); tick();
    check("mthi_wreg", wreg_o, 0);
    drive(8'h10, '0, '0, 5'd2, 1'b1); tick();
    check("mthi_mfhi", wdata_o, 32'h00001234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
